il_ram_sched: RTL and testbench
===============================

# il_ram_sched

Scheduler for the shared turbo-interleaver RAM. It arbitrates between two PB requesters and sequences one complete transaction at a time on behalf of the granted requester. A transaction is a write phase of `len` words, then a one-cycle turnaround, then a read phase of `len/4` quad requests. The block sits between the decoder channel front-ends and the interleaver RAM/enable logic. It owns the PB length/offset table and the RAM write/read address counters.

## Interface
- No parameters. Address width is fixed at 12; PB table is fixed (see Operation).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 2: per-requester transaction request; level, sampled only in IDLE.
- `pb_sel0`, `pb_sel1` in 2 each: PB size code for requester 0/1, sampled with grant. Codes: 0=PB16, 1=PB136, 2=PB520, 3=EX.
- `gnt` out 2: one-hot grant, held from LOAD through DONE.
- `busy` out 1: high in any state other than IDLE.
- `wr_vld` in 1: granted requester presents a write word.
- `wr_rdy` out 1: write beat accepted when `wr_vld & wr_rdy`.
- `ram_wen` out 1: RAM write strobe.
- `ram_waddr` out 12: RAM write address.
- `rd_rdy` in 1: downstream accepts a read request.
- `rd_en` out 1: read request strobe.
- `ram_raddr` out 12: RAM read (quad) address.
- `pb_len` out 12: latched length of the current transaction.
- `pb_offset` out 12: latched RAM offset of the current transaction.
- `done` out 2: one-cycle completion pulse to the served requester.

## Operation
- PB table (len, offset):
  - PB16: 0x040, 0x000
  - PB136: 0x220, 0x040
  - PB520: 0x820, 0x260
  - EX: 0x00A, 0x000
- Read count is `len>>2`: 16, 136, 520, 2.
- States: IDLE, LOAD, WRITE, TURN, READ, DONE.
- IDLE:
  - If `req` is nonzero, select the winner. Single request wins outright; if both request, requester `ptr` wins.
  - Register `gnt`, `pb_len`, `pb_offset` from the winner's `pb_sel`, then go to LOAD.
- LOAD: `cnt` <= 0, then go to WRITE.
- WRITE:
  - `wr_rdy` = 1; `ram_wen` = `wr_vld`; `ram_waddr` = `pb_offset + cnt`.
  - On an accepted beat, `cnt` increments.
  - On the accepted beat with `cnt == pb_len-1`: clear `cnt`, go to TURN.
  - When `wr_vld` is low, the block stalls indefinitely with no timeout.
- TURN: one idle cycle; no strobes asserted. Then go to READ.
- READ:
  - `rd_en` = `rd_rdy`; `ram_raddr` = `pb_offset + cnt`.
  - `cnt` increments on `rd_en`.
  - On `rd_en` with `cnt == (pb_len>>2)-1`, go to DONE.
- DONE:
  - `done` = `gnt` for this cycle only.
  - `ptr` <= index of the requester not served.
  - Clear `gnt`, go to IDLE.
- Arithmetic:
  - 12-bit adds, modulo 4096. No table entry overflows (max 0x260+0x81F = 0xA7F).
- Request and select sampling:
  - `req` and `pb_sel` changes after grant are ignored.
  - A requester dropping `req` mid-transaction does not abort it.
- Simultaneous events:
  - A new `req` arriving while busy is not registered; it must be held until IDLE.
  - A `req` held through DONE is eligible in the following IDLE cycle, and `ptr` already reflects the update.
- Reset:
  - All registers clear: state=IDLE, `cnt`=0, `ptr`=0, `gnt`=0, `pb_len`=0, `pb_offset`=0.
  - A reset mid-transaction abandons it; no `done` pulse is issued.

## Timing
- Reset values of all outputs: 0.
- State, `cnt`, `gnt`, `pb_len`, `pb_offset` and `ptr` are registered.
- `wr_rdy`, `ram_wen`, `rd_en`, the addresses, `busy` and `done` are combinational from registered state. `ram_wen` and `rd_en` also depend on `wr_vld` / `rd_rdy` respectively; there is no extra latency.
- Latency, with `req` sampled in IDLE at cycle 0:
  - `gnt` and `busy` are high from cycle 1 (LOAD).
  - `wr_rdy` is high from cycle 2.
- Unstalled transaction length: 1 LOAD + len WRITE + 1 TURN + len/4 READ + 1 DONE cycles. PB16 takes 83 cycles from LOAD to DONE inclusive.
- Back-to-back throughput: one IDLE cycle minimum between transactions.

## Test plan
- Reset, then `req`=01 with `pb_sel0`=0 and `wr_vld`/`rd_rdy` tied high:
  - `gnt`=01 at cycle 1.
  - 64 `ram_wen` pulses with addresses 0x000..0x03F.
  - One TURN cycle.
  - 16 `rd_en` pulses with addresses 0x000..0x00F.
  - `done`=01 for one cycle, 83 cycles after LOAD.
- `req`=10, `pb_sel1`=2:
  - 2080 writes at 0x260..0xA7F.
  - 520 reads at 0x260..0x467.
  - `pb_len`=0x820 and `pb_offset`=0x260 held throughout.
- `req`=11 held continuously, both EX:
  - Grants alternate 01, 10, 01.
  - Each transaction issues 10 writes and 2 reads.
  - One IDLE cycle separates transactions.
- PB136 with `wr_vld` toggling 1/0 and `rd_rdy` low for 5 cycles mid-read:
  - `cnt` holds during stalls.
  - Exactly 544 writes and 136 reads occur, with no skipped or duplicated addresses.
- `rst` asserted in WRITE at beat 30 of PB16:
  - Next cycle: all outputs 0, `done` never pulses.
  - A subsequent `req`=11 grants requester 0.
- `req0` dropped and `pb_sel0` changed during the write phase:
  - The transaction completes with the original length and offset.
  - `done`=01 is still issued.

Source files
------------

// File: rtl/il_ram_sched.sv
// Shared turbo-interleaver RAM scheduler: arbitrates two PB requesters and runs one
// write / turnaround / quad-read transaction at a time for the granted requester.
module il_ram_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  pb_sel0,
    input  logic [1:0]  pb_sel1,
    output logic [1:0]  gnt,
    output logic        busy,
    input  logic        wr_vld,
    output logic        wr_rdy,
    output logic        ram_wen,
    output logic [11:0] ram_waddr,
    input  logic        rd_rdy,
    output logic        rd_en,
    output logic [11:0] ram_raddr,
    output logic [11:0] pb_len,
    output logic [11:0] pb_offset,
    output logic [1:0]  done
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StTurn,
        StRead,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        ptr_q, ptr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [11:0] pb_len_q, pb_len_d;
    logic [11:0] pb_offset_q, pb_offset_d;

    logic        win_idx;
    logic [1:0]  win_sel;
    logic        wr_fire;
    logic        rd_fire;
    logic        wr_last;
    logic        rd_last;

    function automatic logic [11:0] tbl_len(input logic [1:0] sel);
        logic [11:0] len;
        case (sel)
            2'd0:    len = 12'h040;
            2'd1:    len = 12'h220;
            2'd2:    len = 12'h820;
            default: len = 12'h00A;
        endcase
        return len;
    endfunction

    function automatic logic [11:0] tbl_offset(input logic [1:0] sel);
        logic [11:0] off;
        case (sel)
            2'd0:    off = 12'h000;
            2'd1:    off = 12'h040;
            2'd2:    off = 12'h260;
            default: off = 12'h000;
        endcase
        return off;
    endfunction

    // Single requester wins outright; on contention the round-robin pointer decides.
    always_comb begin
        win_idx = ptr_q;
        if (req == 2'b01) begin
            win_idx = 1'b0;
        end else if (req == 2'b10) begin
            win_idx = 1'b1;
        end
        win_sel = win_idx ? pb_sel1 : pb_sel0;
    end

    assign wr_fire = (state_q == StWrite) && wr_vld;
    assign rd_fire = (state_q == StRead) && rd_rdy;
    assign wr_last = (cnt_q == (pb_len_q - 12'd1));
    assign rd_last = (cnt_q == ((pb_len_q >> 2) - 12'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 12'd0;
            ptr_q       <= 1'b0;
            gnt_q       <= 2'b00;
            pb_len_q    <= 12'd0;
            pb_offset_q <= 12'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            pb_len_q    <= pb_len_d;
            pb_offset_q <= pb_offset_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        pb_len_d    = pb_len_q;
        pb_offset_d = pb_offset_q;
        case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    gnt_d       = win_idx ? 2'b10 : 2'b01;
                    pb_len_d    = tbl_len(win_sel);
                    pb_offset_d = tbl_offset(win_sel);
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = 12'd0;
                state_d = StWrite;
            end
            StWrite: begin
                if (wr_fire) begin
                    if (wr_last) begin
                        cnt_d   = 12'd0;
                        state_d = StTurn;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
            end
            StTurn: begin
                state_d = StRead;
            end
            StRead: begin
                if (rd_fire) begin
                    cnt_d = cnt_q + 12'd1;
                    if (rd_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Pointer moves to the requester that was not just served.
                ptr_d   = gnt_q[0];
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        gnt       = gnt_q;
        busy      = (state_q != StIdle);
        wr_rdy    = (state_q == StWrite);
        ram_wen   = wr_fire;
        ram_waddr = (state_q == StWrite) ? (pb_offset_q + cnt_q) : 12'd0;
        rd_en     = rd_fire;
        ram_raddr = (state_q == StRead) ? (pb_offset_q + cnt_q) : 12'd0;
        pb_len    = pb_len_q;
        pb_offset = pb_offset_q;
        done      = (state_q == StDone) ? gnt_q : 2'b00;
    end

endmodule

// File: tb/tb_il_ram_sched.sv
// Directed self-checking bench for il_ram_sched: full transactions per PB size,
// arbitration fairness, stalls, mid-transaction reset and ignored request changes.
module tb_il_ram_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  pb_sel0;
    logic [1:0]  pb_sel1;
    logic [1:0]  gnt;
    logic        busy;
    logic        wr_vld;
    logic        wr_rdy;
    logic        ram_wen;
    logic [11:0] ram_waddr;
    logic        rd_rdy;
    logic        rd_en;
    logic [11:0] ram_raddr;
    logic [11:0] pb_len;
    logic [11:0] pb_offset;
    logic [1:0]  done;

    int n_cmp = 0;
    int n_err = 0;

    il_ram_sched u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .pb_sel0   (pb_sel0),
        .pb_sel1   (pb_sel1),
        .gnt       (gnt),
        .busy      (busy),
        .wr_vld    (wr_vld),
        .wr_rdy    (wr_rdy),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .rd_rdy    (rd_rdy),
        .rd_en     (rd_en),
        .ram_raddr (ram_raddr),
        .pb_len    (pb_len),
        .pb_offset (pb_offset),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt"}, 32'(gnt), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " wr_rdy"}, 32'(wr_rdy), 32'd0);
        check({tag, " ram_wen"}, 32'(ram_wen), 32'd0);
        check({tag, " ram_waddr"}, 32'(ram_waddr), 32'd0);
        check({tag, " rd_en"}, 32'(rd_en), 32'd0);
        check({tag, " ram_raddr"}, 32'(ram_raddr), 32'd0);
        check({tag, " pb_len"}, 32'(pb_len), 32'd0);
        check({tag, " pb_offset"}, 32'(pb_offset), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    // Entered #2 after an edge of an IDLE cycle; returns #2 after the first IDLE edge
    // following DONE. wmode 1 toggles wr_vld; stall_at >= 0 drops rd_rdy for 5 cycles
    // once that many reads are done; drop_at >= 0 releases req and changes pb_sel0
    // after that many writes.
    task automatic run_txn(input string tag, input logic [1:0] rq, input logic [1:0] s0,
                           input logic [1:0] s1, input bit keep, input int wmode,
                           input int stall_at, input int drop_at, input logic [1:0] exp_gnt,
                           input int exp_len, input int exp_off, input int exp_cycles);
        int  writes;
        int  reads;
        int  stall_cnt;
        int  cyc;
        int  done_cyc;
        bit  done_seen;
        bit  tbl_bad;
        writes    = 0;
        reads     = 0;
        stall_cnt = 0;
        done_cyc  = 0;
        done_seen = 1'b0;
        tbl_bad   = 1'b0;
        req     = rq;
        pb_sel0 = s0;
        pb_sel1 = s1;
        wr_vld  = 1'b0;
        rd_rdy  = 1'b0;
        @(posedge clk);
        #1;
        if (!keep) req = 2'b00;
        #1;
        check({tag, " load gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, " load busy"}, 32'(busy), 32'd1);
        check({tag, " load wr_rdy"}, 32'(wr_rdy), 32'd0);
        check({tag, " load pb_len"}, 32'(pb_len), 32'(exp_len));
        check({tag, " load pb_offset"}, 32'(pb_offset), 32'(exp_off));
        for (cyc = 2; cyc < exp_len * 3 + 200; cyc++) begin
            @(posedge clk);
            #1;
            wr_vld = (wmode == 0) ? 1'b1 : 1'(cyc % 2);
            if (stall_at >= 0 && reads == stall_at && stall_cnt < 5) begin
                rd_rdy = 1'b0;
                stall_cnt++;
            end else begin
                rd_rdy = 1'b1;
            end
            if (drop_at >= 0 && writes >= drop_at) begin
                req     = 2'b00;
                pb_sel0 = 2'd3;
            end
            #1;
            if (pb_len !== 12'(exp_len) || pb_offset !== 12'(exp_off) || gnt !== exp_gnt) begin
                tbl_bad = 1'b1;
            end
            if (ram_wen) begin
                check({tag, " waddr"}, 32'(ram_waddr), 32'((exp_off + writes) % 4096));
                writes++;
            end
            if (rd_en) begin
                check({tag, " raddr"}, 32'(ram_raddr), 32'((exp_off + reads) % 4096));
                reads++;
            end
            if (done != 2'b00) begin
                check({tag, " done"}, 32'(done), 32'(exp_gnt));
                done_seen = 1'b1;
                done_cyc  = cyc;
                break;
            end
        end
        check({tag, " done seen"}, 32'(done_seen), 32'd1);
        check({tag, " writes"}, 32'(writes), 32'(exp_len));
        check({tag, " reads"}, 32'(reads), 32'(exp_len / 4));
        check({tag, " len/off/gnt held"}, 32'(tbl_bad), 32'd0);
        if (exp_cycles > 0) check({tag, " done cycle"}, 32'(done_cyc), 32'(exp_cycles));
        @(posedge clk);
        #1;
        wr_vld = 1'b0;
        rd_rdy = 1'b0;
        #1;
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle gnt"}, 32'(gnt), 32'd0);
        check({tag, " idle done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int  w;
        bit  seen_done;
        rst     = 1'b1;
        req     = 2'b00;
        pb_sel0 = 2'd0;
        pb_sel1 = 2'd0;
        wr_vld  = 1'b0;
        rd_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #2;

        // PB16 on requester 0: 64 writes, 16 reads, DONE is the 83rd cycle from LOAD.
        run_txn("pb16", 2'b01, 2'd0, 2'd0, 1'b0, 0, -1, -1, 2'b01, 12'h040, 12'h000, 83);
        // PB520 on requester 1.
        run_txn("pb520", 2'b10, 2'd0, 2'd2, 1'b0, 0, -1, -1, 2'b10, 12'h820, 12'h260, 2603);
        // Both requesting EX continuously: grants alternate with one IDLE in between.
        run_txn("rr0", 2'b11, 2'd3, 2'd3, 1'b1, 0, -1, -1, 2'b01, 12'h00A, 12'h000, 15);
        run_txn("rr1", 2'b11, 2'd3, 2'd3, 1'b1, 0, -1, -1, 2'b10, 12'h00A, 12'h000, 15);
        run_txn("rr2", 2'b11, 2'd3, 2'd3, 1'b0, 0, -1, -1, 2'b01, 12'h00A, 12'h000, 15);
        // PB136 with toggling wr_vld and a 5-cycle read stall.
        run_txn("pb136", 2'b01, 2'd1, 2'd0, 1'b0, 1, 60, -1, 2'b01, 12'h220, 12'h040, 0);

        // Reset during WRITE after 30 accepted beats; ptr is 1 going in.
        req     = 2'b01;
        pb_sel0 = 2'd0;
        @(posedge clk);
        #1;
        req    = 2'b00;
        wr_vld = 1'b1;
        w      = 0;
        for (int i = 0; i < 200 && w < 30; i++) begin
            @(posedge clk);
            #2;
            if (ram_wen) w++;
        end
        check("rst beats", 32'(w), 32'd30);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_all_zero("rst mid");
        rst       = 1'b0;
        wr_vld    = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (done != 2'b00) seen_done = 1'b1;
        end
        check("rst no done", 32'(seen_done), 32'd0);
        run_txn("post rst", 2'b11, 2'd3, 2'd3, 1'b0, 0, -1, -1, 2'b01, 12'h00A, 12'h000, 15);

        // req0 released and pb_sel0 changed mid-write: original PB16 still completes.
        run_txn("drop", 2'b01, 2'd0, 2'd0, 1'b1, 0, -1, 20, 2'b01, 12'h040, 12'h000, 83);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
